fitbit_display_scheduler: RTL
=============================

Name: fitbit_display_scheduler

Overview:
Controller that sequences the tracker's 4-digit display among the four activity metrics: steps, distance, over-32 seconds and high-activity seconds. It generates the 1 Hz system tick and rotates the display mode every DWELL_TICKS ticks, or immediately on a button press. On each refresh it snapshots the selected metric, saturates it, and runs a serial 16-cycle binary-to-BCD conversion. It then publishes digits and flags atomically to the segment driver.

Parameters:
TICK_DIV, 50000000, clk cycles per tick; tick asserted when divider wraps at TICK_DIV-1
DWELL_TICKS, 2, ticks spent in each mode before auto-advance (min 1)
BCD_MAX, 9999, saturation ceiling for displayed value

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
steps_total  in  32  total step count
dist_miles  in  16  distance, fixed-point miles
over32_sec  in  16  seconds above 32 steps/s
high_act_sec  in  16  high-activity seconds
btn_next  in  1  synchronous one-cycle pulse; advance mode now
hold  in  1  level; freezes auto-rotation
tick  out  1  one-cycle 1 Hz pulse for the metric counters
disp_mode  out  2  mode of the published value (0 steps, 1 miles, 2 over32, 3 high-act)
bcd  out  16  four BCD digits, [15:12] most significant
is_miles  out  1  published value is distance
si  out  1  published value was saturated
bcd_update  out  1  one-cycle pulse when outputs change
busy  out  1  conversion in progress
digit_blank  out  4  leading-zero blank mask (see Optional Feature)

Behaviour:
- Reset (async): all outputs 0; divider, dwell counter, sel_mode = 0; FSM IDLE; pending = 0. Reset mid-conversion aborts it and leaves the outputs unchanged from their reset values.
- Tick: divider counts 0..TICK_DIV-1 and wraps. tick = 1 in the cycle the divider equals TICK_DIV-1.
- Rotation, evaluated on tick:
  - If hold = 0 and dwell = DWELL_TICKS-1: sel_mode increments mod 4 (3 -> 0) and dwell clears.
  - Otherwise dwell increments (saturating).
  - hold = 1 freezes dwell.
- btn_next: advances sel_mode and clears dwell regardless of hold. If btn_next coincides with a rotating tick, sel_mode advances by one only.
- Refresh request: raised by every tick and every sel_mode change; the same cycle counts once.
- FSM: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
  - Request sampled at edge k: edge k+1 LOAD snapshots the sel_mode source.
  - Saturation in LOAD: value > BCD_MAX becomes BCD_MAX with si_snap = 1. For steps, the full 32 bits are compared.
  - Edges k+2..k+17: 16 double-dabble steps. Each step adds 3 to any digit >= 5, then shifts left one bit.
  - Edge k+18 (DONE): bcd, disp_mode, is_miles (= mode 1), si register together; bcd_update = 1 for that one cycle.
- busy = 1 in LOAD, SHIFT and DONE.
- Request while busy: sets pending (one deep; further requests merge). Pending is serviced on the cycle after DONE, using the then-current sel_mode.
- Source changes after LOAD do not affect the in-flight result.
- Outputs hold their value between bcd_update pulses.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: in DONE, digit_blank[i] = 1 for each zero digit above the most significant nonzero digit. digit 0 is never blanked; value 0 gives 4'b1110.
- Undefined: digit_blank is tied to 4'b0000. No other behaviour changes.

Decomposition:
- Package fitbit_pkg holds:
  - mode encodings MODE_STEPS = 0, MODE_MILES = 1, MODE_OVER32 = 2, MODE_HIGHACT = 3
  - BCD width 16
  - FSM state encoding
- One sub-module: bcd_serial_converter (start, 16-bit bin in, busy, done, 16-bit bcd out), owning the LOAD/SHIFT sequencing. The scheduler owns the tick, rotation, pending and publish logic.

Test Plan:
- TICK_DIV = 4, DWELL_TICKS = 2, reset released: tick every 4th cycle. First bcd_update 18 cycles after the first tick. disp_mode sequence 0,0,1,1,2,2,3,3,0 across ticks.
- steps_total = 12345 in mode 0 -> bcd = 16'h9999, si = 1, is_miles = 0. steps_total = 4321 -> bcd = 16'h4321, si = 0.
- dist_miles = 7 with btn_next pulsed while in mode 0 -> disp_mode = 1, is_miles = 1, bcd = 16'h0007. Under LOAD_ZERO... with LEADING_ZERO_BLANK_EN defined, digit_blank = 4'b1110.
- hold = 1 for 6 ticks -> disp_mode stays constant and bcd_update still fires each tick. btn_next during hold -> mode advances once.
- btn_next coinciding with a rotating tick -> mode advances by exactly 1 with a single conversion. Second request mid-SHIFT -> pending set, exactly one extra bcd_update.
- reset asserted at SHIFT step 8 -> all outputs 0 immediately, no bcd_update. After release, normal sequencing restarts from mode 0.

Source files
------------

// File: rtl/fitbit_pkg.sv
// Shared definitions for the display scheduler: metric mode encodings,
// BCD word width and the refresh FSM state encoding.
package fitbit_pkg;

  localparam int BCD_W = 16;

  localparam logic [1:0] MODE_STEPS   = 2'd0;
  localparam logic [1:0] MODE_MILES   = 2'd1;
  localparam logic [1:0] MODE_OVER32  = 2'd2;
  localparam logic [1:0] MODE_HIGHACT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/bcd_serial_converter.sv
// Serial double-dabble converter: loads a 16-bit binary value on start and
// performs one add-3/shift step per clock for 16 clocks, then pulses done
// for one cycle with the result held on bcd_o.
module bcd_serial_converter
  import fitbit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [BCD_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  logic [BCD_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  // Adds 3 to every BCD digit that is 5 or more, ahead of the left shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Next-state: load on start, otherwise one dabble step per cycle while active.
  always_comb begin
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done_d   = 1'b0;
    if (start_i && !active_q) begin
      bin_d    = bin_i;
      bcd_d    = '0;
      cnt_d    = 4'd0;
      active_d = 1'b1;
    end else if (active_q) begin
      {bcd_d, bin_d} = {add3(bcd_q), bin_q} << 1;
      cnt_d          = cnt_q + 4'd1;
      if (cnt_q == 4'd15) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end
  end

  // Conversion registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= 4'd0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign busy_o = active_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/fitbit_display_scheduler.sv
// Display scheduler: 1 Hz tick generation, metric rotation (auto dwell or
// button), refresh request/pending handling, saturation and atomic publish
// of the BCD conversion result.
// Optional build macro LEADING_ZERO_BLANK_EN enables the leading-zero blank
// mask on digit_blank; otherwise digit_blank is constant zero.
module fitbit_display_scheduler
  import fitbit_pkg::*;
#(
  parameter int TICK_DIV    = 50000000,
  parameter int DWELL_TICKS = 2,
  parameter int BCD_MAX     = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] steps_total,
  input  logic [15:0] dist_miles,
  input  logic [15:0] over32_sec,
  input  logic [15:0] high_act_sec,
  input  logic        btn_next,
  input  logic        hold,
  output logic        tick,
  output logic [1:0]  disp_mode,
  output logic [15:0] bcd,
  output logic        is_miles,
  output logic        si,
  output logic        bcd_update,
  output logic        busy,
  output logic [3:0]  digit_blank
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW_W  = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_TICKS - 1);
  localparam logic [31:0]      SAT_MAX    = 32'(BCD_MAX);

  // Clamps a metric to the display ceiling; bit 16 flags that clamping occurred.
  function automatic logic [BCD_W:0] saturate(input logic [31:0] v);
    if (v > SAT_MAX) begin
      return {1'b1, SAT_MAX[BCD_W-1:0]};
    end
    return {1'b0, v[BCD_W-1:0]};
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Blanks zero digits above the most significant nonzero digit; digit 0 stays lit.
  function automatic logic [3:0] blank_mask(input logic [BCD_W-1:0] d);
    logic [3:0] m;
    m[3] = (d[15:12] == 4'd0);
    m[2] = m[3] && (d[11:8] == 4'd0);
    m[1] = m[2] && (d[7:4] == 4'd0);
    m[0] = 1'b0;
    return m;
  endfunction
`endif

  logic [DIV_W-1:0] div_q, div_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [1:0]       sel_q, sel_d;
  logic             tick_w, rot_w, adv_w, req_w;

  sched_state_e     state_q, state_d;
  logic             pending_q, pending_d;
  logic             publish_w;

  logic [31:0]      src_w;
  logic [BCD_W:0]   sat_w;
  logic [1:0]       mode_snap_q;
  logic             si_snap_q;

  logic             conv_start_w, conv_busy_w, conv_done_w;
  logic [BCD_W-1:0] conv_bcd_w;

  logic [BCD_W-1:0] bcd_q;
  logic [1:0]       mode_q;
  logic             is_miles_q, si_q, bcd_update_q;

  assign tick_w = (div_q == DIV_LAST);

  // Tick divider: free-running count that wraps at TICK_DIV-1.
  always_comb begin
    div_d = tick_w ? '0 : div_q + DIV_W'(1);
  end

  // Rotation: auto-advance after the dwell period unless held; the button
  // always advances, and a coincident rotating tick still advances only once.
  always_comb begin
    rot_w   = tick_w && !hold && (dwell_q == DWELL_LAST);
    adv_w   = btn_next || rot_w;
    sel_d   = sel_q;
    dwell_d = dwell_q;
    if (adv_w) begin
      sel_d   = sel_q + 2'd1;
      dwell_d = '0;
    end else if (tick_w && !hold && (dwell_q != DWELL_LAST)) begin
      dwell_d = dwell_q + DW_W'(1);
    end
    req_w = tick_w || adv_w;
  end

  // Tick and rotation state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      dwell_q <= '0;
      sel_q   <= MODE_STEPS;
    end else begin
      div_q   <= div_d;
      dwell_q <= dwell_d;
      sel_q   <= sel_d;
    end
  end

  // Source select and saturation of the currently selected metric.
  always_comb begin
    unique case (sel_q)
      MODE_STEPS:  src_w = steps_total;
      MODE_MILES:  src_w = {16'd0, dist_miles};
      MODE_OVER32: src_w = {16'd0, over32_sec};
      default:     src_w = {16'd0, high_act_sec};
    endcase
    sat_w = saturate(src_w);
  end

  // Refresh FSM next-state: requests while busy merge into a single pending.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    publish_w    = 1'b0;
    conv_start_w = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_w) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        conv_start_w = 1'b1;
        state_d      = ST_SHIFT;
        if (req_w) pending_d = 1'b1;
      end
      ST_SHIFT: begin
        if (req_w) pending_d = 1'b1;
        if (conv_done_w) begin
          publish_w = 1'b1;
          state_d   = ST_DONE;
        end
      end
      default: begin
        if (pending_q || req_w) begin
          state_d   = ST_LOAD;
          pending_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Refresh FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Snapshot of mode and saturation flag, taken in LOAD alongside the converter load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_snap_q <= MODE_STEPS;
      si_snap_q   <= 1'b0;
    end else if (state_q == ST_LOAD) begin
      mode_snap_q <= sel_q;
      si_snap_q   <= sat_w[BCD_W];
    end
  end

  bcd_serial_converter u_conv (
    .clk     (clk),
    .reset   (reset),
    .start_i (conv_start_w),
    .bin_i   (sat_w[BCD_W-1:0]),
    .busy_o  (conv_busy_w),
    .done_o  (conv_done_w),
    .bcd_o   (conv_bcd_w)
  );

  // Publish: all display outputs change together with a one-cycle update pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_q        <= '0;
      mode_q       <= MODE_STEPS;
      is_miles_q   <= 1'b0;
      si_q         <= 1'b0;
      bcd_update_q <= 1'b0;
    end else begin
      bcd_update_q <= publish_w;
      if (publish_w) begin
        bcd_q      <= conv_bcd_w;
        mode_q     <= mode_snap_q;
        is_miles_q <= (mode_snap_q == MODE_MILES);
        si_q       <= si_snap_q;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] blank_q;

  // Blank mask is published with the digits it describes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_q <= 4'b0000;
    end else if (publish_w) begin
      blank_q <= blank_mask(conv_bcd_w);
    end
  end

  assign digit_blank = blank_q;
`else
  assign digit_blank = 4'b0000;
`endif

  assign tick       = tick_w;
  assign disp_mode  = mode_q;
  assign bcd        = bcd_q;
  assign is_miles   = is_miles_q;
  assign si         = si_q;
  assign bcd_update = bcd_update_q;
  assign busy       = (state_q != ST_IDLE) || conv_busy_w;

endmodule
